rv_divider: RTL
===============

RV_DIVIDER -- requirements
Module: rv_divider

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width.
REQ-002 SHALL have port clk  input  1  core clock; all state on rising edge.
REQ-003 SHALL have port rst_b  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port div_req_valid  input  1  request present.
REQ-005 SHALL have port div_req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port div_opcode  input  2  funct3[1:0] of M-ext divide group: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port div_src1  input  XLEN  dividend.
REQ-008 SHALL have port div_src2  input  XLEN  divisor.
REQ-009 SHALL have port div_flush  input  1  abort in-flight operation (pipeline flush).
REQ-010 SHALL have port div_resp_valid  output  1  result available.
REQ-011 SHALL have port div_resp_ready  input  1  consumer takes result.
REQ-012 SHALL have port div_result  output  XLEN  quotient or remainder per opcode.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL assert div_req_ready only in IDLE; request accepted when div_req_valid & div_req_ready; opcode and operands captured on that edge.
REQ-015 SHALL, on accept with div_src2 != 0, move IDLE->CALC, load 6-bit iteration counter with 0, and convert signed operands (DIV/REM) to magnitudes.
REQ-016 SHALL in CALC perform one restoring shift-subtract step per cycle, producing one quotient bit MSB first; after XLEN steps (counter == XLEN-1) move CALC->DONE.
REQ-017 SHALL give latency: accept edge at cycle 0, div_resp_valid high at cycle XLEN+1 for nonzero divisor.
REQ-018 SHALL, on accept with div_src2 == 0, go directly IDLE->DONE (resp_valid at cycle 1) with quotient all ones and remainder = div_src1 (unsigned and signed).
REQ-019 SHALL negate the quotient when signed op and operand signs differ; SHALL give the remainder the sign of the dividend; unsigned ops SHALL skip sign correction.
REQ-020 SHALL, for signed overflow (src1 = 2^(XLEN-1) negative, src2 = all ones), produce quotient 0x80000000 and remainder 0 (XLEN=32), in normal XLEN+1 latency.
REQ-021 SHALL hold div_resp_valid and div_result stable in DONE until div_resp_valid & div_resp_ready, then return to IDLE; no new request accepted on that same edge.
REQ-022 SHALL, on div_flush high in any state, return to IDLE on the next edge, drop div_resp_valid, and discard results; flush has priority over accept and response handshake in the same cycle.
REQ-023 SHALL drive div_result to 0 when div_resp_valid is low.

Reset
REQ-024 SHALL on rst_b low immediately enter IDLE, clear counter, quotient, remainder and captured operand registers; div_req_ready = 1, div_resp_valid = 0, div_result = 0.
REQ-025 SHALL, on reset asserted mid-CALC or in DONE, abandon the operation with no response emitted after reset release.

Structure
REQ-026 SHALL place div opcode encodings (DIV/DIVU/REM/REMU) and the FSM state enum in the shared core package.
REQ-027 SHALL be a single module; no sub-module, since the adder reuse pattern (subtract via inverted operand plus carry-in) is inlined.

Verification
REQ-028 SHALL cover DIVU 100/7: accept at cycle 0 -> resp_valid at cycle 33, result 14; REMU same operands -> 2.
REQ-029 SHALL cover DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1).
REQ-030 SHALL cover DIV 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5.
REQ-031 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-032 SHALL cover back-pressure: resp_ready low 5 cycles after resp_valid -> result held stable, req_ready low throughout, IDLE one cycle after handshake.
REQ-033 SHALL cover div_flush at cycle 10 of CALC -> IDLE next edge, no resp_valid; following DIVU 9/3 -> 3 with normal latency.

Source files
------------

// File: rtl/rv_divider_pkg.sv
// Shared definitions for the RV32/64 M-extension divide unit: opcode encodings,
// FSM state encoding and small opcode decode helpers.
package rv_divider_pkg;

  // funct3[1:0] of the M-extension divide group
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/rv_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// magnitudes internally, sign fix-up applied when the last bit is produced.
module rv_divider
  import rv_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            div_req_valid,
  output logic            div_req_ready,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  input  logic            div_flush,
  output logic            div_resp_valid,
  input  logic            div_resp_ready,
  output logic [XLEN-1:0] div_result
);

  localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);

  div_state_e      state_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] result_q;
  logic            is_rem_q;
  logic            q_neg_q;
  logic            r_neg_q;

  // Request decode and operand magnitudes
  div_op_e         op;
  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign op     = div_op_e'(div_opcode);
  assign accept = div_req_valid && div_req_ready;
  assign a_neg  = op_is_signed(op) && div_src1[XLEN-1];
  assign b_neg  = op_is_signed(op) && div_src2[XLEN-1];
  assign a_mag  = a_neg ? (~div_src1 + 1'b1) : div_src1;
  assign b_mag  = b_neg ? (~div_src2 + 1'b1) : div_src2;

  // One restoring step. The partial remainder's top bit is kept out of the
  // adder: if it is set the shifted value already exceeds any divisor, and the
  // low XLEN bits of the difference are still exact.
  logic [XLEN-1:0] shift_lo;
  logic [XLEN:0]   sum;
  logic            ge;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign shift_lo = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign sum      = {1'b0, shift_lo} + {1'b0, ~dvs_q} + {{XLEN{1'b0}}, 1'b1};
  assign ge       = rem_q[XLEN-1] | sum[XLEN];
  assign rem_next = ge ? sum[XLEN-1:0] : shift_lo;
  assign quo_next = {quo_q[XLEN-2:0], ge};
  assign q_fix    = q_neg_q ? (~quo_next + 1'b1) : quo_next;
  assign r_fix    = r_neg_q ? (~rem_next + 1'b1) : rem_next;

  // Handshake flags decode straight from the state register; result_q is
  // zero outside DONE so it can drive the port directly.
  assign div_req_ready  = (state_q == ST_IDLE);
  assign div_resp_valid = (state_q == ST_DONE);
  assign div_result     = result_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others; blocking here would chain the step.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else if (div_flush) begin
      // Flush beats accept and the response handshake in the same cycle
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            is_rem_q <= op_is_rem(op);
            dvs_q    <= b_mag;
            cnt_q    <= '0;
            if (div_src2 == '0) begin
              // Divide by zero: quotient all ones, remainder is the dividend
              state_q  <= ST_DONE;
              result_q <= op_is_rem(op) ? div_src1 : '1;
            end else begin
              state_q <= ST_CALC;
              quo_q   <= a_mag;
              rem_q   <= '0;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
            end
          end
        end
        ST_CALC: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) begin
            state_q  <= ST_DONE;
            result_q <= is_rem_q ? r_fix : q_fix;
          end
        end
        ST_DONE: begin
          if (div_resp_ready) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          result_q <= '0;
        end
      endcase
    end
  end

endmodule
